// File: rtl/keypad_bcd_encoder_if.sv
// Digit-entry bus between the front-panel keypad encoder and its surroundings.
// Handshake: load is a one-cycle strobe from the encoder and has no ready.
// bcd_out is valid in every cycle load is high and holds between strobes.
// The consumer must take the digit in the strobe cycle.
interface keypad_bcd_encoder_if;
    logic       enable;
    logic       digits_clr;
    logic [9:0] keypad;
    logic [3:0] bcd_out;
    logic       load;
    logic [1:0] digit_count;
    logic       full;

    // Panel / controller side: drives keys and entry control, observes digits.
    modport master (
        output enable,
        output digits_clr,
        output keypad,
        input  bcd_out,
        input  load,
        input  digit_count,
        input  full
    );

    // Encoder side.
    modport slave (
        input  enable,
        input  digits_clr,
        input  keypad,
        output bcd_out,
        output load,
        output digit_count,
        output full
    );
endinterface

// File: rtl/keypad_bcd_encoder.sv
// Front-panel keypad encoder.
// Debounces a raw 10-key keypad and accepts only a single key at a time.
// Each accepted press produces one BCD digit with a one-cycle load strobe.
// It counts accepted digits and refuses entry once MAX_DIGITS have been taken.
// The current FSM state is exported on state_dbg (IDLE=0, DEBOUNCE=1, EMIT=2, WAIT_RELEASE=3).
module keypad_bcd_encoder #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned MAX_DIGITS      = 3
) (
    input  logic                  clk,
    input  logic                  clear,
    keypad_bcd_encoder_if.slave   kp,
    output logic [1:0]            state_dbg
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        DEBOUNCE     = 2'd1,
        EMIT         = 2'd2,
        WAIT_RELEASE = 2'd3
    } state_t;

    localparam logic [7:0] CNT_LAST   = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [1:0] DIGITS_MAX = 2'(MAX_DIGITS);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [9:0] key_q, key_d;
    logic [3:0] bcd_q, bcd_d;
    logic       load_q, load_d;
    logic [1:0] count_q, count_d;
    logic       full;

    // True when exactly one key line is active.
    function automatic logic is_one_hot(input logic [9:0] v);
        return (v != 10'd0) && ((v & (v - 10'd1)) == 10'd0);
    endfunction

    // Key index of a one-hot key vector: bit k gives digit k.
    function automatic logic [3:0] encode_key(input logic [9:0] v);
        logic [3:0] digit;
        digit = 4'd0;
        for (int k = 0; k < 10; k++) begin
            if (v[k]) begin
                digit = 4'(k);
            end
        end
        return digit;
    endfunction

    // Full follows the digit counter directly so both change on the same edge.
    assign full = (count_q == DIGITS_MAX);

    // Next-state, debounce counter, digit register and digit counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        key_d   = key_q;
        bcd_d   = bcd_q;
        load_d  = 1'b0;
        count_d = count_q;

        // The digit counter is cleared before it can be incremented.
        // A strobe that is already on the bus when digits_clr arrives still happens.
        if (kp.digits_clr) begin
            count_d = 2'd0;
        end else if ((state_q == EMIT) && load_q && (count_q != DIGITS_MAX)) begin
            count_d = count_q + 2'd1;
        end

        if (!kp.enable) begin
            // Entry is locked out: abandon any press in progress.
            // The digit and count are kept.
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (is_one_hot(kp.keypad)) begin
                        key_d   = kp.keypad;
                        cnt_d   = 8'd1;
                        state_d = DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (kp.keypad != key_q) begin
                        state_d = IDLE;
                    end else if (cnt_q == CNT_LAST) begin
                        if (kp.digits_clr) begin
                            // Panel clear races the acceptance: drop this press.
                            state_d = WAIT_RELEASE;
                        end else begin
                            state_d = EMIT;
                            if (!full) begin
                                load_d = 1'b1;
                                bcd_d  = encode_key(key_q);
                            end
                        end
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                EMIT: begin
                    state_d = WAIT_RELEASE;
                end
                WAIT_RELEASE: begin
                    // Ignore held keys and rollover until the pad is fully released.
                    if (kp.keypad == 10'd0) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and output registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (clear) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            key_q   <= 10'd0;
            bcd_q   <= 4'd0;
            load_q  <= 1'b0;
            count_q <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            key_q   <= key_d;
            bcd_q   <= bcd_d;
            load_q  <= load_d;
            count_q <= count_d;
        end
    end

    assign kp.bcd_out     = bcd_q;
    assign kp.load        = load_q;
    assign kp.digit_count = count_q;
    assign kp.full        = full;
    assign state_dbg      = state_q;

endmodule

// File: tb/tb_keypad_bcd_encoder.sv
// Bench for keypad_bcd_encoder: directed scenarios plus randomized key activity.
// Every cycle is compared against a press-level reference model.
module tb_keypad_bcd_encoder;
  localparam int DEB  = 4;
  localparam int MAXD = 3;

  logic clk = 1'b0;
  logic clear;
  logic [1:0] state_dbg;
  keypad_bcd_encoder_if kp();

  keypad_bcd_encoder #(.DEBOUNCE_CYCLES(DEB), .MAX_DIGITS(MAXD)) dut (
    .clk(clk),
    .clear(clear),
    .kp(kp),
    .state_dbg(state_dbg)
  );

  // clock
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int edge_no = 0;
  int strobes = 0;
  int load_edges[$];
  logic [3:0] load_bcds[$];
  logic [3:0] exp_q[$];

  // reference model state: press in qualification, accepted press, release lock
  int m_cand;
  int m_held;
  bit m_emitting;
  bit m_latched;
  bit m_load;
  int m_bcd;
  int m_count;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, edge_no);
    end
  endtask

  function automatic int key_index(input logic [9:0] v);
    int ones;
    int idx;
    ones = 0;
    idx = -1;
    for (int k = 0; k < 10; k++) begin
      if (v[k]) begin
        ones++;
        idx = k;
      end
    end
    return (ones == 1) ? idx : -1;
  endfunction

  task automatic model_reset();
    m_cand = -1;
    m_held = 0;
    m_emitting = 0;
    m_latched = 0;
    m_load = 0;
    m_bcd = 0;
    m_count = 0;
  endtask

  // One clock edge of the reference behaviour, using inputs sampled at that edge.
  task automatic model_step();
    int nxt_count;
    bit nxt_load;
    int idx;
    if (clear) begin
      model_reset();
    end else begin
      nxt_count = m_count;
      nxt_load = 0;
      if (kp.digits_clr) nxt_count = 0;
      else if (m_emitting && m_load && m_count < MAXD) nxt_count = m_count + 1;

      if (!kp.enable) begin
        m_cand = -1;
        m_emitting = 0;
        m_latched = 0;
      end else if (m_emitting) begin
        m_emitting = 0;
        m_latched = 1;
      end else if (m_latched) begin
        if (kp.keypad == 10'd0) m_latched = 0;
      end else if (m_cand >= 0) begin
        if (kp.keypad != (10'd1 << m_cand)) begin
          m_cand = -1;
        end else begin
          m_held++;
          if (m_held == DEB) begin
            if (kp.digits_clr) begin
              m_latched = 1;
            end else begin
              m_emitting = 1;
              if (m_count < MAXD) begin
                nxt_load = 1;
                m_bcd = m_cand;
                exp_q.push_back(4'(m_cand));
              end
            end
            m_cand = -1;
          end
        end
      end else begin
        idx = key_index(kp.keypad);
        if (idx >= 0) begin
          m_cand = idx;
          m_held = 1;
        end
      end
      m_load = nxt_load;
      m_count = nxt_count;
    end
  endtask

  // driver: one clock, model update, then compare 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    model_step();
    edge_no++;
    #1;
    chk("load", 32'(kp.load), 32'(m_load));
    chk("bcd_out", 32'(kp.bcd_out), 32'(m_bcd));
    chk("digit_count", 32'(kp.digit_count), 32'(m_count));
    chk("full", 32'(kp.full), 32'(m_count == MAXD));
    if (kp.load) begin
      strobes++;
      load_edges.push_back(edge_no);
      load_bcds.push_back(kp.bcd_out);
      chk("strobe_queued", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) chk("strobe_digit", 32'(kp.bcd_out), 32'(exp_q.pop_front()));
    end
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic press(input int key, input int hold, input int rel);
    kp.keypad = 10'd1 << key;
    run(hold);
    kp.keypad = 10'd0;
    run(rel);
  endtask

  task automatic rand_cycles(input int n);
    repeat (n) begin
      kp.digits_clr = ($urandom_range(0, 24) == 0);
      clear = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 29) == 0) kp.enable = ~kp.enable;
      step();
    end
    kp.digits_clr = 1'b0;
    clear = 1'b0;
  endtask

  initial begin
    int base;
    int bidx;
    int e0;
    int kind;
    model_reset();
    clear = 1'b1;
    kp.enable = 1'b0;
    kp.digits_clr = 1'b0;
    kp.keypad = 10'd0;
    run(2);
    clear = 1'b0;
    chk("reset_state", 32'(state_dbg), 32'd0);
    chk("reset_bcd", 32'(kp.bcd_out), 32'd0);
    chk("reset_count", 32'(kp.digit_count), 32'd0);

    // single press of key 3
    kp.enable = 1'b1;
    base = strobes;
    e0 = edge_no + 1;
    kp.keypad = 10'b0000001000;
    run(10);
    kp.keypad = 10'd0;
    run(3);
    chk("t1_strobes", 32'(strobes - base), 32'd1);
    if (load_edges.size() != 0) chk("t1_latency", 32'(load_edges[$] - e0), 32'(DEB - 1));
    chk("t1_bcd", 32'(kp.bcd_out), 32'd3);
    chk("t1_count", 32'(kp.digit_count), 32'd1);

    // bounce rejection on key 7
    base = strobes;
    repeat (3) begin
      kp.keypad = 10'd1 << 7;
      run(2);
      kp.keypad = 10'd0;
      run(2);
    end
    chk("t2_bounce_quiet", 32'(strobes - base), 32'd0);
    press(7, 6, 2);
    chk("t2_strobes", 32'(strobes - base), 32'd1);
    chk("t2_bcd", 32'(kp.bcd_out), 32'd7);

    // saturation at MAX_DIGITS
    kp.digits_clr = 1'b1;
    run(1);
    kp.digits_clr = 1'b0;
    base = strobes;
    press(1, 6, 2);
    press(2, 6, 2);
    press(3, 6, 2);
    chk("t3_strobes", 32'(strobes - base), 32'd3);
    chk("t3_full", 32'(kp.full), 32'd1);
    press(4, 6, 2);
    chk("t3_sat_strobes", 32'(strobes - base), 32'd3);
    chk("t3_sat_bcd", 32'(kp.bcd_out), 32'd3);
    chk("t3_sat_count", 32'(kp.digit_count), 32'd3);

    // multi-hot and rollover
    kp.digits_clr = 1'b1;
    run(1);
    kp.digits_clr = 1'b0;
    base = strobes;
    kp.keypad = 10'b0000100010;
    run(10);
    chk("t4_multi_quiet", 32'(strobes - base), 32'd0);
    chk("t4_state_idle", 32'(state_dbg), 32'd0);
    kp.keypad = 10'd0;
    run(1);
    kp.keypad = 10'd1 << 2;
    run(6);
    kp.keypad = (10'd1 << 2) | (10'd1 << 9);
    run(8);
    kp.keypad = 10'd0;
    run(2);
    chk("t4_rollover", 32'(strobes - base), 32'd1);

    // enable dropped mid-debounce
    base = strobes;
    kp.keypad = 10'd1 << 5;
    run(2);
    kp.enable = 1'b0;
    run(3);
    kp.keypad = 10'd0;
    run(1);
    kp.enable = 1'b1;
    run(2);
    chk("t5_enable_drop", 32'(strobes - base), 32'd0);

    // digits_clr on the edge that would enter EMIT
    press(6, 6, 2);
    base = strobes;
    kp.keypad = 10'd1 << 8;
    run(3);
    kp.digits_clr = 1'b1;
    run(1);
    kp.digits_clr = 1'b0;
    chk("t5_clr_count", 32'(kp.digit_count), 32'd0);
    run(3);
    kp.keypad = 10'd0;
    run(2);
    chk("t5_clr_cancel", 32'(strobes - base), 32'd0);

    // clear during the EMIT cycle
    kp.keypad = 10'd1 << 4;
    run(4);
    chk("t5_emit_seen", 32'(kp.load), 32'd1);
    clear = 1'b1;
    run(1);
    clear = 1'b0;
    kp.keypad = 10'd0;
    chk("t5_clear_load", 32'(kp.load), 32'd0);
    chk("t5_clear_bcd", 32'(kp.bcd_out), 32'd0);
    chk("t5_clear_count", 32'(kp.digit_count), 32'd0);
    chk("t5_clear_full", 32'(kp.full), 32'd0);
    chk("t5_clear_state", 32'(state_dbg), 32'd0);
    run(2);

    // back-to-back presses, one released cycle apart
    base = strobes;
    bidx = load_edges.size();
    kp.keypad = 10'd1 << 0;
    run(5);
    kp.keypad = 10'd0;
    run(1);
    kp.keypad = 10'd1 << 9;
    run(6);
    kp.keypad = 10'd0;
    run(2);
    chk("t6_strobes", 32'(strobes - base), 32'd2);
    if (load_edges.size() >= bidx + 2) begin
      chk("t6_spacing", 32'(load_edges[bidx + 1] - load_edges[bidx]), 32'(DEB + 2));
      chk("t6_first_bcd", 32'(load_bcds[bidx]), 32'd0);
      chk("t6_second_bcd", 32'(load_bcds[bidx + 1]), 32'd9);
    end

    // randomized key activity
    for (int i = 0; i < 400; i++) begin
      kind = $urandom_range(0, 9);
      if (kind <= 5) begin
        kp.keypad = 10'd1 << $urandom_range(0, 9);
        rand_cycles($urandom_range(1, 8));
        kp.keypad = 10'd0;
        rand_cycles($urandom_range(0, 3));
      end else if (kind <= 7) begin
        kp.keypad = 10'd1 << $urandom_range(0, 9);
        repeat ($urandom_range(2, 6)) begin
          rand_cycles($urandom_range(1, 3));
          kp.keypad = ($urandom_range(0, 1) == 0) ? 10'd0 : (10'd1 << $urandom_range(0, 9));
        end
        kp.keypad = 10'd0;
        rand_cycles(2);
      end else begin
        kp.keypad = 10'($urandom_range(0, 1023));
        rand_cycles($urandom_range(1, 5));
        kp.keypad = 10'd0;
        rand_cycles(1);
      end
      if (!kp.enable && $urandom_range(0, 1) == 0) kp.enable = 1'b1;
    end
    kp.keypad = 10'd0;
    kp.enable = 1'b1;
    run(4);
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
